// File: rtl/vcm_focus_stepper.sv
// Lens VCM focus sequencer: steps toward a target code, one I2C write per step.
// Ports: iCLK/iRST_N (sync, active-low), iTARGET/iTARGET_VALID/oTARGET_READY request,
// oPOSITION/oBUSY/oDONE/oERROR status, VCM_DATA/ENABLE/iEND to the I2C VCM block.
// Optional feature macro: VCM_SLEW_LIMIT_EN (limit each write to MAX_STEP codes).
module vcm_focus_stepper #(
  parameter logic [9:0] MAX_STEP       = 10'd32,
  parameter int         SETTLE_CYCLES  = 50_000,
  parameter int         TIMEOUT_CYCLES = 5_000_000,
  parameter logic [3:0] SLEW_CODE      = 4'h0
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [9:0]  iTARGET,
  input  logic        iTARGET_VALID,
  output logic        oTARGET_READY,
  output logic [9:0]  oPOSITION,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oERROR,
  output logic [15:0] VCM_DATA,
  output logic        ENABLE,
  input  logic        iEND
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT_END,
    SETTLE
  } state_t;

`ifdef VCM_SLEW_LIMIT_EN
  localparam logic [10:0] STEP_LIM = {1'b0, MAX_STEP};
`else
  // Bit 10 puts the limit above any reachable distance,
  // so every move collapses to a single write.
  localparam logic [10:0] STEP_LIM = {1'b1, MAX_STEP};
`endif

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] STL_LAST = 32'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [9:0]  target_q, target_d;
  logic [9:0]  pos_q, pos_d;
  logic [9:0]  next_q, next_d;
  logic [15:0] data_q, data_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] stl_q, stl_d;
  logic [1:0]  sync_q;
  logic        end_prev_q;
  logic        end_evt;

  logic signed [10:0] diff;
  logic [10:0] mag;
  logic [11:0] up;
  logic [9:0]  step_up;
  logic [9:0]  step_dn;
  logic [9:0]  calc_code;

  assign end_evt = sync_q[1] & ~end_prev_q;

  // Step arithmetic, saturating inside 0..1023.
  always_comb begin
    diff = $signed({1'b0, target_q}) - $signed({1'b0, pos_q});
    mag  = diff[10] ? $unsigned(-diff) : $unsigned(diff);
    up   = {2'b00, pos_q} + {1'b0, STEP_LIM};
    step_up = (up > 12'd1023) ? 10'd1023 : up[9:0];
    step_dn = ({1'b0, pos_q} < STEP_LIM) ? 10'd0
                                         : pos_q - STEP_LIM[9:0];
    calc_code = (mag <= STEP_LIM) ? target_q
                                  : (diff[10] ? step_dn : step_up);
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    pos_d    = pos_q;
    next_d   = next_q;
    data_d   = data_q;
    en_d     = en_q;
    done_d   = 1'b0;
    err_d    = err_q;
    tmo_d    = tmo_q;
    stl_d    = stl_q;
    unique case (state_q)
      IDLE: begin
        if (iTARGET_VALID) begin
          target_d = iTARGET;
          err_d    = 1'b0;
          if (iTARGET == pos_q) done_d  = 1'b1;
          else                  state_d = CALC;
        end
      end
      CALC: begin
        next_d  = calc_code;
        data_d  = {2'b00, calc_code, SLEW_CODE};
        state_d = ISSUE;
      end
      ISSUE: begin
        en_d    = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_END;
      end
      WAIT_END: begin
        if (end_evt) begin
          en_d    = 1'b0;
          pos_d   = next_q;
          stl_d   = '0;
          state_d = SETTLE;
        end else if (tmo_q == TMO_LAST) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      SETTLE: begin
        if (SETTLE_CYCLES == 0 || stl_q == STL_LAST) begin
          if (pos_q == target_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = CALC;
          end
        end else begin
          stl_d = stl_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      target_q   <= '0;
      pos_q      <= '0;
      next_q     <= '0;
      data_q     <= {12'h000, SLEW_CODE};
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      stl_q      <= '0;
      sync_q     <= '0;
      end_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      pos_q      <= pos_d;
      next_q     <= next_d;
      data_q     <= data_d;
      en_q       <= en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      stl_q      <= stl_d;
      sync_q     <= {sync_q[0], iEND};
      end_prev_q <= sync_q[1];
    end
  end

  assign oTARGET_READY = (state_q == IDLE);
  assign oBUSY         = (state_q != IDLE);
  assign oPOSITION     = pos_q;
  assign oDONE         = done_q;
  assign oERROR        = err_q;
  assign VCM_DATA      = data_q;
  assign ENABLE        = en_q;

endmodule
